// File: rtl/jstk_move_gen_if.sv
// Move-event handshake bundle between the joystick move generator and its consumer.
// The producer holds valid/dir until ready; drop flags an event lost while one was pending.
`timescale 1ns/1ps
interface jstk_move_gen_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_dir;
  logic       move_drop;

  modport master (output move_valid, output move_dir, output move_drop, input move_ready);
  modport slave  (input move_valid, input move_dir, input move_drop, output move_ready);
endinterface

// File: rtl/jstk_move_gen.sv
// Debounced, priority-encoded, auto-repeating joystick move events; first event one cycle after the
// DEB_CYCLES-th stable sample. Backpressure: held until ready; events arriving while stalled are dropped.
`timescale 1ns/1ps
module jstk_move_gen #(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 20000000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      dir_in,
  output logic [3:0]      dir_held,
  jstk_move_gen_if.master mv
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, REPEAT} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit               DEB_ONE  = (DEB_CYCLES == 1);

  state_t           state_q, state_d;
  logic [1:0]       ldir_q, ldir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             valid_q, valid_d;
  logic [1:0]       mdir_q, mdir_d;
  logic             drop_q, drop_d;
  logic [3:0]       held_q, held_d;
  logic             cand_vld;
  logic [1:0]       cand;
  logic             restart;
  logic             issue;

  // Fixed priority up > down > left > right.
  always_comb begin
    cand_vld = |dir_in;
    cand     = 2'd3;
    if (dir_in[3])      cand = 2'd0;
    else if (dir_in[2]) cand = 2'd1;
    else if (dir_in[1]) cand = 2'd2;
  end

  always_comb begin
    state_d = state_q;
    ldir_d  = ldir_q;
    cnt_d   = cnt_q;
    restart = 1'b0;
    issue   = 1'b0;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (cand_vld) restart = 1'b1;
      end
      DEBOUNCE: begin
        if (!cand_vld) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cand != ldir_q) begin
          restart = 1'b1;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          issue   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!cand_vld) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cand != ldir_q) begin
          restart = 1'b1;
        end else if (REPEAT_EN) begin
          if (cnt_q == DLY_LAST) begin
            state_d = REPEAT;
            cnt_d   = '0;
            issue   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      REPEAT: begin
        if (!cand_vld) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cand != ldir_q) begin
          restart = 1'b1;
        end else if (cnt_q == PER_LAST) begin
          cnt_d = '0;
          issue = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A new direction counts as its own first sample; with a 1-sample filter it is accepted at once.
    if (restart) begin
      ldir_d = cand;
      if (DEB_ONE) begin
        state_d = HELD;
        cnt_d   = '0;
        issue   = 1'b1;
      end else begin
        state_d = DEBOUNCE;
        cnt_d   = CNT_W'(1);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    mdir_d  = mdir_q;
    drop_d  = 1'b0;
    if (valid_q && mv.move_ready) valid_d = 1'b0;
    if (issue) begin
      if (!valid_q || mv.move_ready) begin
        valid_d = 1'b1;
        mdir_d  = ldir_d;
      end else begin
        drop_d = 1'b1;
      end
    end
    held_d = ((state_d == HELD) || (state_d == REPEAT)) ? (4'b1000 >> ldir_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ldir_q  <= 2'd0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      mdir_q  <= 2'd0;
      drop_q  <= 1'b0;
      held_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      ldir_q  <= ldir_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      mdir_q  <= mdir_d;
      drop_q  <= drop_d;
      held_q  <= held_d;
    end
  end

  assign mv.move_valid = valid_q;
  assign mv.move_dir   = mdir_q;
  assign mv.move_drop  = drop_q;
  assign dir_held      = held_q;

endmodule
